// File: rtl/bid_pkg.sv
// Shared types and constants for the bid arbiter: FSM encoding, widths,
// default tuning parameters and a saturating counter helper.
package bid_pkg;

    localparam int N_REQ   = 4;
    localparam int REF_MIN = 5000;
    localparam int TIMEOUT = 16;
    localparam int INS_W   = 64;
    localparam int CHK_W   = 16;
    localparam int REF_W   = 13;
    localparam int IDX_W   = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        REPORT = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [REF_W-1:0] sat_inc(input logic [REF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bid_arbiter_if.sv
// Bus bundle between requesters/check engine and the arbiter.
// Handshake: the engine takes eng_ins on a cycle where eng_valid and
// eng_ready are both high; eng_done/eng_pass/eng_check and res_*/alert
// are single-cycle pulses qualified by their own valid bit.
interface bid_arbiter_if;
    import bid_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*INS_W-1:0] ins_in;
    logic [N_REQ-1:0]       gnt;
    logic                   eng_valid;
    logic [INS_W-1:0]       eng_ins;
    logic                   eng_ready;
    logic                   eng_done;
    logic                   eng_pass;
    logic [CHK_W-1:0]       eng_check;
    logic                   res_valid;
    logic [IDX_W-1:0]       res_id;
    logic [INS_W-1:0]       res_ins;
    logic [CHK_W-1:0]       res_check;
    logic                   alert;
    logic                   fault;

    // Arbiter side.
    modport slave (
        input  req, ins_in, eng_ready, eng_done, eng_pass, eng_check,
        output gnt, eng_valid, eng_ins, res_valid, res_id, res_ins,
               res_check, alert, fault
    );

    // Environment side (requesters and check engine).
    modport master (
        output req, ins_in, eng_ready, eng_done, eng_pass, eng_check,
        input  gnt, eng_valid, eng_ins, res_valid, res_id, res_ins,
               res_check, alert, fault
    );

endinterface

// File: rtl/bid_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo the requester count.
module bid_rr_pick
    import bid_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    // Scan from ptr upward; the first hit wins and later hits are ignored.
    always_comb begin
        any    = 1'b0;
        winner = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[ptr + IDX_W'(i)]) begin
                any    = 1'b1;
                winner = ptr + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bid_arbiter.sv
// Round-robin arbiter that forwards one requester's instruction to a check
// engine, waits (bounded) for its result and reports it, raising alert on a
// pass once enough checks have completed.
module bid_arbiter
    import bid_pkg::state_t, bid_pkg::IDLE, bid_pkg::ISSUE, bid_pkg::WAIT,
           bid_pkg::REPORT, bid_pkg::FAULT, bid_pkg::INS_W, bid_pkg::REF_W,
           bid_pkg::IDX_W, bid_pkg::sat_inc;
#(
    parameter int N_REQ   = bid_pkg::N_REQ,
    parameter int REF_MIN = bid_pkg::REF_MIN,
    parameter int TIMEOUT = bid_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              RST,
    bid_arbiter_if.slave      bus,
    output state_t            dbg_state,
    output logic [IDX_W-1:0]  dbg_ptr,
    output logic [REF_W-1:0]  dbg_refnum
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx_q;
    logic [INS_W-1:0] ins_q;
    logic [TW-1:0]    timer;
    logic [REF_W-1:0] refnum;
    logic [REF_W-1:0] refnum_inc;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    bid_rr_pick u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign refnum_inc    = sat_inc(refnum);
    assign bus.eng_valid = (state == ISSUE);
    assign bus.eng_ins   = (state == ISSUE) ? ins_q : '0;
    assign dbg_state     = state;
    assign dbg_ptr       = ptr;
    assign dbg_refnum    = refnum;

    // Control FSM with registered pulses; res_* hold until the next
    // REPORT or FAULT overwrites them.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            ptr           <= '0;
            idx_q         <= '0;
            ins_q         <= '0;
            timer         <= '0;
            refnum        <= '0;
            bus.gnt       <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_ins   <= '0;
            bus.res_check <= '0;
            bus.alert     <= 1'b0;
            bus.fault     <= 1'b0;
        end else begin
            bus.gnt       <= '0;
            bus.res_valid <= 1'b0;
            bus.alert     <= 1'b0;
            bus.fault     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        idx_q             <= pick_idx;
                        ins_q             <= bus.ins_in[pick_idx*INS_W +: INS_W];
                        bus.gnt[pick_idx] <= 1'b1;
                        ptr   <= (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.eng_ready) begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (bus.eng_done) begin
                        bus.res_valid <= 1'b1;
                        bus.res_id    <= idx_q;
                        bus.res_ins   <= ins_q;
                        bus.res_check <= bus.eng_check;
                        bus.alert     <= bus.eng_pass && (32'(refnum_inc) >= REF_MIN);
                        refnum        <= refnum_inc;
                        state         <= REPORT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        bus.fault     <= 1'b1;
                        bus.res_id    <= '0;
                        bus.res_ins   <= '0;
                        bus.res_check <= '0;
                        state         <= FAULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REPORT:  state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bid_arbiter.sv
// Directed bench for bid_arbiter: reset values, single grant, stall in
// ISSUE, round-robin order, timeout, done-vs-timeout priority, mid-flight
// reset and the refnum threshold/saturation behaviour of alert.
module tb_bid_arbiter;
    import bid_pkg::*;

    logic clk;
    logic rst;
    state_t           dbg_state;
    logic [IDX_W-1:0] dbg_ptr;
    logic [REF_W-1:0] dbg_refnum;
    int total;
    int bad;

    logic [63:0] w0, w1, w2, w3;

    bid_arbiter_if bus();

    bid_arbiter dut (
        .clk        (clk),
        .RST        (rst),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_ptr    (dbg_ptr),
        .dbg_refnum (dbg_refnum)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drive_txn(input logic [3:0] r, input bit hold, input int delay,
                             input logic pass, input logic [15:0] chk,
                             output logic [3:0] g, output logic [63:0] ins_seen,
                             output logic rv, output logic flt, output logic al,
                             output logic [1:0] rid, output logic [63:0] rins,
                             output logic [15:0] rchk);
        bus.req = r;
        bus.eng_ready = 1'b1;
        tick();
        g = bus.gnt;
        ins_seen = bus.eng_ins;
        if (!hold) bus.req = '0;
        tick();
        repeat (delay) tick();
        bus.eng_done = 1'b1;
        bus.eng_pass = pass;
        bus.eng_check = chk;
        tick();
        rv = bus.res_valid;
        flt = bus.fault;
        al = bus.alert;
        rid = bus.res_id;
        rins = bus.res_ins;
        rchk = bus.res_check;
        bus.eng_done = 1'b0;
        bus.eng_pass = 1'b0;
        bus.eng_check = '0;
        tick();
    endtask

    logic [3:0]  g;
    logic [63:0] ins_seen, rins;
    logic        rv, flt, al;
    logic [1:0]  rid;
    logic [15:0] rchk;

    task automatic test_reset();
        total++; if (bus.gnt !== 4'b0) begin bad++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
        total++; if (bus.eng_valid !== 1'b0) begin bad++; $display("FAIL rst_eng_valid: got %b want 0", bus.eng_valid); end
        total++; if (bus.eng_ins !== 64'h0) begin bad++; $display("FAIL rst_eng_ins: got %h want 0", bus.eng_ins); end
        total++; if ({bus.res_valid, bus.alert, bus.fault} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got %b want 000", {bus.res_valid, bus.alert, bus.fault}); end
        total++; if ({bus.res_id, bus.res_ins, bus.res_check} !== 82'h0) begin bad++; $display("FAIL rst_res: got %h want 0", {bus.res_id, bus.res_ins, bus.res_check}); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
        total++; if (dbg_ptr !== 2'd0) begin bad++; $display("FAIL rst_ptr: got %0d want 0", dbg_ptr); end
        total++; if (dbg_refnum !== 13'd0) begin bad++; $display("FAIL rst_refnum: got %0d want 0", dbg_refnum); end
    endtask

    task automatic test_single();
        drive_txn(4'b0100, 1'b0, 2, 1'b1, 16'h1234, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if (g !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", g); end
        total++; if (ins_seen !== 64'hA5A5_0000_0000_0001) begin bad++; $display("FAIL single_eng_ins: got %h want a5a5000000000001", ins_seen); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL single_res_valid: got %b want 1", rv); end
        total++; if (rid !== 2'd2) begin bad++; $display("FAIL single_res_id: got %0d want 2", rid); end
        total++; if (rins !== 64'hA5A5_0000_0000_0001) begin bad++; $display("FAIL single_res_ins: got %h want a5a5000000000001", rins); end
        total++; if (rchk !== 16'h1234) begin bad++; $display("FAIL single_res_check: got %h want 1234", rchk); end
        total++; if (al !== 1'b0) begin bad++; $display("FAIL single_alert: got %b want 0", al); end
        // Result fields hold through idle cycles; the pulse does not.
        tick(); tick();
        total++; if ({bus.res_valid, bus.res_id, bus.res_check} !== {1'b0, 2'd2, 16'h1234}) begin bad++; $display("FAIL single_hold: got %h want %h", {bus.res_valid, bus.res_id, bus.res_check}, {1'b0, 2'd2, 16'h1234}); end
        total++; if (dbg_ptr !== 2'd3) begin bad++; $display("FAIL single_ptr: got %0d want 3", dbg_ptr); end
    endtask

    task automatic test_stall();
        // ptr=3, only requester 0 asks: wrap gives 0. Engine not ready for one cycle.
        bus.req = 4'b0001;
        bus.eng_ready = 1'b0;
        tick();
        total++; if ({bus.gnt, bus.eng_valid} !== 5'b00011) begin bad++; $display("FAIL stall_first: got %b want 00011", {bus.gnt, bus.eng_valid}); end
        bus.req = '0;
        tick();
        total++; if ({bus.gnt, bus.eng_valid} !== 5'b00001) begin bad++; $display("FAIL stall_second: got %b want 00001", {bus.gnt, bus.eng_valid}); end
        total++; if (bus.eng_ins !== w0) begin bad++; $display("FAIL stall_eng_ins: got %h want %h", bus.eng_ins, w0); end
        bus.eng_ready = 1'b1;
        tick();
        total++; if (dbg_state !== WAIT) begin bad++; $display("FAIL stall_wait: got %0d want %0d", dbg_state, WAIT); end
        bus.eng_done = 1'b1;
        bus.eng_check = 16'h0F0F;
        tick();
        total++; if ({bus.res_valid, bus.res_id, bus.res_ins} !== {1'b1, 2'd0, w0}) begin bad++; $display("FAIL stall_res: got %h want %h", {bus.res_valid, bus.res_id, bus.res_ins}, {1'b1, 2'd0, w0}); end
        bus.eng_done = 1'b0;
        bus.eng_check = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_txn(4'b1111, 1'b1, 3, 1'b0, 16'(i + 1), g, ins_seen, rv, flt, al, rid, rins, rchk);
            total++; if (g !== exp_g[i]) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", i, g, exp_g[i]); end
            total++; if (rid !== 2'(i % 4)) begin bad++; $display("FAIL rr_id%0d: got %0d want %0d", i, rid, i % 4); end
        end
        bus.req = '0;
        total++; if (dbg_refnum !== 13'd5) begin bad++; $display("FAIL rr_refnum: got %0d want 5", dbg_refnum); end
    endtask

    task automatic test_timeout();
        bit stayed;
        // ptr=1: requester 3 wins and ptr wraps to 0.
        drive_txn(4'b1000, 1'b0, 0, 1'b1, 16'hBEEF, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if ({g, rid, rchk} !== {4'b1000, 2'd3, 16'hBEEF}) begin bad++; $display("FAIL to_pre: got %h want %h", {g, rid, rchk}, {4'b1000, 2'd3, 16'hBEEF}); end
        bus.req = 4'b0001;
        bus.eng_ready = 1'b1;
        tick();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL to_gnt: got %b want 0001", bus.gnt); end
        bus.req = '0;
        tick();
        stayed = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (dbg_state !== WAIT || bus.fault !== 1'b0) stayed = 1'b0;
        end
        total++; if (stayed !== 1'b1) begin bad++; $display("FAIL to_early: got %b want 1", stayed); end
        tick();
        total++; if ({bus.fault, bus.res_valid} !== 2'b10) begin bad++; $display("FAIL to_fault: got %b want 10", {bus.fault, bus.res_valid}); end
        total++; if ({bus.res_id, bus.res_ins, bus.res_check} !== 82'h0) begin bad++; $display("FAIL to_res_zero: got %h want 0", {bus.res_id, bus.res_ins, bus.res_check}); end
        total++; if (dbg_refnum !== 13'd6) begin bad++; $display("FAIL to_refnum: got %0d want 6", dbg_refnum); end
        tick();
        total++; if ({bus.fault, dbg_state} !== {1'b0, IDLE}) begin bad++; $display("FAIL to_after: got %h want %h", {bus.fault, dbg_state}, {1'b0, IDLE}); end
        drive_txn(4'b1111, 1'b0, 0, 1'b0, 16'h0001, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if (g !== 4'b0010) begin bad++; $display("FAIL to_next_gnt: got %b want 0010", g); end
    endtask

    task automatic test_same_cycle();
        drive_txn(4'b0100, 1'b0, 15, 1'b0, 16'h5A5A, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if ({rv, flt} !== 2'b10) begin bad++; $display("FAIL edge_res: got %b want 10", {rv, flt}); end
        total++; if ({g, rchk} !== {4'b0100, 16'h5A5A}) begin bad++; $display("FAIL edge_data: got %h want %h", {g, rchk}, {4'b0100, 16'h5A5A}); end
        total++; if ({bus.fault, dbg_refnum} !== {1'b0, 13'd8}) begin bad++; $display("FAIL edge_after: got %h want %h", {bus.fault, dbg_refnum}, {1'b0, 13'd8}); end
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0001;
        bus.eng_ready = 1'b1;
        tick();
        bus.req = '0;
        tick();
        tick(); tick(); tick();
        total++; if (dbg_state !== WAIT) begin bad++; $display("FAIL mid_in_wait: got %0d want %0d", dbg_state, WAIT); end
        rst = 1'b1;
        #1;
        total++; if ({bus.gnt, bus.eng_valid, bus.res_valid, bus.alert, bus.fault} !== 8'h0) begin bad++; $display("FAIL mid_pulses: got %b want 0", {bus.gnt, bus.eng_valid, bus.res_valid, bus.alert, bus.fault}); end
        total++; if ({bus.eng_ins, bus.res_id, bus.res_ins, bus.res_check} !== 146'h0) begin bad++; $display("FAIL mid_data: got %h want 0", {bus.eng_ins, bus.res_id, bus.res_ins, bus.res_check}); end
        total++; if ({dbg_state, dbg_ptr, dbg_refnum} !== {IDLE, 2'd0, 13'd0}) begin bad++; $display("FAIL mid_state: got %h want %h", {dbg_state, dbg_ptr, dbg_refnum}, {IDLE, 2'd0, 13'd0}); end
        tick();
        rst = 1'b0;
        // A stray done while idle must be ignored.
        bus.eng_done = 1'b1;
        bus.eng_pass = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        bus.eng_pass = 1'b0;
        tick();
        total++; if ({bus.res_valid, bus.fault, dbg_state} !== {2'b00, IDLE}) begin bad++; $display("FAIL mid_no_result: got %h want %h", {bus.res_valid, bus.fault, dbg_state}, {2'b00, IDLE}); end
    endtask

    task automatic test_refmin();
        apply_reset();
        for (int i = 0; i < 4999; i++)
            drive_txn(4'b0001, 1'b0, 0, 1'b1, 16'h0, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if ({al, dbg_refnum} !== {1'b0, 13'd4999}) begin bad++; $display("FAIL ref_4999: got %h want %h", {al, dbg_refnum}, {1'b0, 13'd4999}); end
        drive_txn(4'b0001, 1'b0, 0, 1'b1, 16'h0, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if ({rv, al, dbg_refnum} !== {2'b11, 13'd5000}) begin bad++; $display("FAIL ref_5000_pass: got %h want %h", {rv, al, dbg_refnum}, {2'b11, 13'd5000}); end
        drive_txn(4'b0001, 1'b0, 0, 1'b0, 16'h0, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if ({rv, al, dbg_refnum} !== {2'b10, 13'd5001}) begin bad++; $display("FAIL ref_5001_fail: got %h want %h", {rv, al, dbg_refnum}, {2'b10, 13'd5001}); end
        for (int i = 0; i < 3190; i++)
            drive_txn(4'b0001, 1'b0, 0, 1'b0, 16'h0, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if (dbg_refnum !== 13'd8191) begin bad++; $display("FAIL ref_8191: got %0d want 8191", dbg_refnum); end
        drive_txn(4'b0001, 1'b0, 0, 1'b1, 16'h0, g, ins_seen, rv, flt, al, rid, rins, rchk);
        total++; if ({al, dbg_refnum} !== {1'b1, 13'd8191}) begin bad++; $display("FAIL ref_saturate: got %h want %h", {al, dbg_refnum}, {1'b1, 13'd8191}); end
    endtask

    // Main sequence.
    initial begin
        total = 0;
        bad = 0;
        w0 = 64'h1111_2222_3333_4444;
        w1 = 64'h5555_6666_7777_8888;
        w2 = 64'hA5A5_0000_0000_0001;
        w3 = 64'hDEAD_BEEF_CAFE_F00D;
        rst = 1'b1;
        bus.req = '0;
        bus.ins_in = {w3, w2, w1, w0};
        bus.eng_ready = 1'b0;
        bus.eng_done = 1'b0;
        bus.eng_pass = 1'b0;
        bus.eng_check = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_single();
        test_stall();
        test_round_robin();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        test_refmin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bid_arbiter.md
BID_ARBITER -- requirements
Module: bid_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, fixed at 4 in this revision.
REQ-002 Parameter REF_MIN, default 5000: minimum completed-check count before alert may assert.
REQ-003 Parameter TIMEOUT, default 16: maximum WAIT cycles before fault.
REQ-004 clk  in  1: single clock; all state on rising edge.
REQ-005 RST  in  1: reset, asynchronous, active-high.
REQ-006 req  in  4: per-requester request, level.
REQ-007 ins_in  in  256: four 64-bit instruction words; requester i at bits [64i+63:64i].
REQ-008 gnt  out  4: one-hot grant, one-cycle pulse.
REQ-009 eng_valid  out  1: instruction offered to check engine.
REQ-010 eng_ins  out  64: instruction to check engine.
REQ-011 eng_ready  in  1: engine accepts eng_ins.
REQ-012 eng_done  in  1: engine result valid, one-cycle pulse.
REQ-013 eng_pass  in  1: engine pass flag, qualified by eng_done.
REQ-014 eng_check  in  16: engine check word, qualified by eng_done.
REQ-015 res_valid  out  1: result pulse.
REQ-016 res_id  out  2: requester index of result.
REQ-017 res_ins  out  64: instruction of result.
REQ-018 res_check  out  16: check word of result.
REQ-019 alert  out  1: pass-with-history pulse, coincident with res_valid.
REQ-020 fault  out  1: engine timeout pulse.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, REPORT, FAULT; unused encodings SHALL go to IDLE.
REQ-022 IDLE: if req != 0, SHALL latch the round-robin winner index and its ins_in word and enter ISSUE; otherwise SHALL stay in IDLE.
REQ-023 Round-robin: search SHALL start at ptr, then ptr+1 mod 4, and so on; after each grant, ptr SHALL become winner+1 mod 4.
REQ-024 gnt SHALL be high, one-hot at the winner, for exactly the first ISSUE cycle.
REQ-025 ISSUE: eng_valid SHALL be 1 and eng_ins SHALL hold the latched word; on eng_valid & eng_ready, SHALL enter WAIT with timer cleared to 0.
REQ-026 eng_done outside WAIT SHALL be ignored.
REQ-027 WAIT: timer SHALL increment each cycle. On eng_done, SHALL latch eng_check and eng_pass, increment refnum, and enter REPORT.
REQ-028 WAIT: if timer == TIMEOUT-1 and no eng_done, SHALL enter FAULT; eng_done in that same cycle SHALL take priority over the timeout.
REQ-029 refnum SHALL be 13 bits and saturate at 8191, never wrapping.
REQ-030 REPORT: res_valid SHALL pulse for one cycle with res_id, res_ins, res_check; alert SHALL equal pass & (refnum >= REF_MIN), using the post-increment value; next state SHALL be IDLE.
REQ-031 FAULT: fault SHALL pulse for one cycle, refnum SHALL be unchanged, res_* SHALL be zero, ptr SHALL keep its advanced value; next state SHALL be IDLE.
REQ-032 Latency: req sampled in IDLE at edge N gives gnt during cycle N+1; with eng_ready=1, WAIT begins at N+2; eng_done at cycle M gives res_valid during M+1.
REQ-033 Requester deassertion after grant SHALL NOT affect the in-flight transaction.
REQ-034 res_id, res_ins, res_check SHALL hold their values until the next REPORT or FAULT.
REQ-035 Outputs SHALL be registered, except eng_valid and eng_ins, which are decoded from registered state.

Reset
REQ-036 While RST=1: state=IDLE, ptr=0, timer=0, refnum=0, latched word, index and check=0.
REQ-037 While RST=1: gnt, eng_valid, res_valid, alert and fault SHALL be 0; eng_ins and res_* SHALL be 0.
REQ-038 Reset asserted mid-transaction SHALL abort it with no res_valid or fault pulse.

Structure
REQ-039 Package bid_pkg SHALL hold the state enum, N_REQ, REF_MIN, TIMEOUT, INS_W=64 and CHK_W=16.
REQ-040 Sub-module bid_rr_pick SHALL be combinational, mapping (req, ptr) to (any, winner index).

Verification
REQ-041 req=4'b1111 held, engine always ready with done 3 cycles later -> gnt sequence 0001, 0010, 0100, 1000, 0001.
REQ-042 Single request req[2], ins=64'hA5A5_0000_0000_0001, eng_check=16'h1234, pass=1, refnum=0 -> res_id=2, res_check=16'h1234, alert=0.
REQ-043 Preload 4999 completions, then a pass -> alert=1 on completion 5000; a fail on completion 5001 -> alert=0.
REQ-044 Withhold eng_done -> fault pulses 16 cycles after WAIT entry, refnum unchanged, next grant goes to the next requester.
REQ-045 eng_done on the same cycle as timer==15 -> res_valid, no fault.
REQ-046 RST asserted during WAIT -> all outputs 0 at once, ptr=0, no res_valid.
